// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between two
// valid/ready requesters and returns a registered, ID-tagged response.
module alu_share_arbiter #(
   parameter int W      = 10,
   parameter int OPW    = 3,
   parameter int FLW    = 4,
   parameter int MAX_OP = 6
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_req0_vld,
   input  logic [W-1:0]   i_req0_arg0,
   input  logic [W-1:0]   i_req0_arg1,
   input  logic [OPW-1:0] i_req0_oper,
   output logic           o_req0_rdy,
   input  logic           i_req1_vld,
   input  logic [W-1:0]   i_req1_arg0,
   input  logic [W-1:0]   i_req1_arg1,
   input  logic [OPW-1:0] i_req1_oper,
   output logic           o_req1_rdy,
   output logic [W-1:0]   o_alu_arg0,
   output logic [W-1:0]   o_alu_arg1,
   output logic [OPW-1:0] o_alu_oper,
   input  logic [W-1:0]   i_alu_result,
   input  logic [FLW-1:0] i_alu_flag,
   output logic           o_rsp_vld,
   input  logic           i_rsp_rdy,
   output logic           o_rsp_id,
   output logic [W-1:0]   o_rsp_result,
   output logic [FLW-1:0] o_rsp_flag,
   output logic           o_rsp_err,
   output logic           o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [OPW-1:0] MAX_OPER = OPW'(MAX_OP);

   state_t         state_r;
   state_t         state_s;
   logic           last_r;
   logic           id_r;
   logic           err_r;
   logic [W-1:0]   arg0_r;
   logic [W-1:0]   arg1_r;
   logic [OPW-1:0] oper_r;
   logic [W-1:0]   result_r;
   logic [FLW-1:0] flag_r;

   logic           grant0_s;
   logic           grant1_s;
   logic           grant_any_s;
   logic           grant_idx_s;
   logic [W-1:0]   g_arg0_s;
   logic [W-1:0]   g_arg1_s;
   logic [OPW-1:0] g_oper_s;
   logic           illegal_s;

   // Round-robin grant and selection of the winning command payload.
   always_comb begin
      grant0_s    = i_req0_vld & (~i_req1_vld | last_r);
      grant1_s    = i_req1_vld & (~i_req0_vld | ~last_r);
      grant_any_s = grant0_s | grant1_s;
      grant_idx_s = 1'b0;
      g_arg0_s    = i_req0_arg0;
      g_arg1_s    = i_req0_arg1;
      g_oper_s    = i_req0_oper;
      if (grant1_s) begin
         grant_idx_s = 1'b1;
         g_arg0_s    = i_req1_arg0;
         g_arg1_s    = i_req1_arg1;
         g_oper_s    = i_req1_oper;
      end else begin
         grant_idx_s = 1'b0;
      end
      illegal_s = (g_oper_s > MAX_OPER);
   end

   // Next-state logic; illegal opcodes skip the ALU cycle entirely.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_any_s) begin
               state_s = illegal_s ? RESP : EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: state_s = RESP;
         RESP: begin
            if (i_rsp_rdy) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Operand, arbitration and response registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_r   <= 1'b1;
         id_r     <= 1'b0;
         err_r    <= 1'b0;
         arg0_r   <= '0;
         arg1_r   <= '0;
         oper_r   <= '0;
         result_r <= '0;
         flag_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_any_s) begin
                  id_r   <= grant_idx_s;
                  last_r <= grant_idx_s;
                  if (illegal_s) begin
                     result_r <= '0;
                     flag_r   <= '0;
                     err_r    <= 1'b1;
                  end else begin
                     arg0_r <= g_arg0_s;
                     arg1_r <= g_arg1_s;
                     oper_r <= g_oper_s;
                  end
               end
            end
            EXEC: begin
               result_r <= i_alu_result;
               flag_r   <= i_alu_flag;
               err_r    <= 1'b0;
            end
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

   assign o_req0_rdy   = (state_r == IDLE) & grant0_s;
   assign o_req1_rdy   = (state_r == IDLE) & grant1_s;
   assign o_alu_arg0   = arg0_r;
   assign o_alu_arg1   = arg1_r;
   assign o_alu_oper   = oper_r;
   assign o_rsp_vld    = (state_r == RESP);
   assign o_rsp_id     = id_r;
   assign o_rsp_result = result_r;
   assign o_rsp_flag   = flag_r;
   assign o_rsp_err    = err_r;
   assign o_busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_req0_vld = 1'b0, i_req1_vld = 1'b0;
   logic [9:0] i_req0_arg0 = 10'd0, i_req0_arg1 = 10'd0;
   logic [9:0] i_req1_arg0 = 10'd0, i_req1_arg1 = 10'd0;
   logic [2:0] i_req0_oper = 3'd0, i_req1_oper = 3'd0;
   logic       o_req0_rdy, o_req1_rdy;
   logic [9:0] o_alu_arg0, o_alu_arg1;
   logic [2:0] o_alu_oper;
   logic [9:0] i_alu_result;
   logic [3:0] i_alu_flag;
   logic       o_rsp_vld;
   logic       i_rsp_rdy = 1'b1;
   logic       o_rsp_id;
   logic [9:0] o_rsp_result;
   logic [3:0] o_rsp_flag;
   logic       o_rsp_err;
   logic       o_busy;

   logic [13:0] alu_out;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [15:0] exp_q[$];

   alu_share_arbiter dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req0_vld(i_req0_vld), .i_req0_arg0(i_req0_arg0), .i_req0_arg1(i_req0_arg1),
      .i_req0_oper(i_req0_oper), .o_req0_rdy(o_req0_rdy),
      .i_req1_vld(i_req1_vld), .i_req1_arg0(i_req1_arg0), .i_req1_arg1(i_req1_arg1),
      .i_req1_oper(i_req1_oper), .o_req1_rdy(o_req1_rdy),
      .o_alu_arg0(o_alu_arg0), .o_alu_arg1(o_alu_arg1), .o_alu_oper(o_alu_oper),
      .i_alu_result(i_alu_result), .i_alu_flag(i_alu_flag),
      .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(i_rsp_rdy), .o_rsp_id(o_rsp_id),
      .o_rsp_result(o_rsp_result), .o_rsp_flag(o_rsp_flag), .o_rsp_err(o_rsp_err),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Behavioural ALU: returns {flag[3:0] = {neg, zero, carry, ovf}, result[9:0]}.
   function automatic logic [13:0] alu_ref(input logic [9:0] a, input logic [9:0] b,
                                           input logic [2:0] op);
      logic [10:0] wide;
      logic [9:0]  r;
      logic [9:0]  amt;
      logic        c, v;
      wide = 11'd0; r = 10'd0; amt = 10'd0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: begin
            wide = {1'b0, a} + {1'b0, b}; r = wide[9:0]; c = wide[10];
            v = (a[9] == b[9]) && (r[9] != a[9]);
         end
         3'd1: begin
            wide = {1'b0, a} - {1'b0, b}; r = wide[9:0]; c = wide[10];
            v = (a[9] != b[9]) && (r[9] != a[9]);
         end
         3'd2: begin
            if (b[9]) begin
               amt = ~b + 10'd1;
               r = $signed(a) >>> amt;
            end else begin
               r = a << b;
            end
         end
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: r = ~(a ^ b);
         default: r = 10'd0;
      endcase
      return {r[9], (r == 10'd0), c, v, r};
   endfunction

   assign alu_out      = alu_ref(o_alu_arg0, o_alu_arg1, o_alu_oper);
   assign i_alu_result = alu_out[9:0];
   assign i_alu_flag   = alu_out[13:10];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_exp(input logic id, input logic [9:0] a, input logic [9:0] b,
                           input logic [2:0] op);
      logic [13:0] m;
      m = alu_ref(a, b, op);
      if (op > 3'd6) exp_q.push_back({id, 10'd0, 4'd0, 1'b1});
      else           exp_q.push_back({id, m[9:0], m[13:10], 1'b0});
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic neg();
      @(negedge i_clk);
   endtask

   task automatic set0(input logic v, input logic [9:0] a, input logic [9:0] b, input logic [2:0] op);
      i_req0_vld = v; i_req0_arg0 = a; i_req0_arg1 = b; i_req0_oper = op;
   endtask

   task automatic set1(input logic v, input logic [9:0] a, input logic [9:0] b, input logic [2:0] op);
      i_req1_vld = v; i_req1_arg0 = a; i_req1_arg1 = b; i_req1_oper = op;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
      check_val("drain", exp_q.size(), 32'd0);
   endtask

   // Holds both requests until n grants were seen, checking who wins first.
   task automatic run_pair(input int n_grants, input logic first_id);
      int g;
      g = 0;
      for (int cyc = 0; cyc < 60 && g < n_grants; cyc++) begin
         neg();
         if (o_req0_rdy | o_req1_rdy) begin
            if (g == 0) check_val("first_grant", {31'd0, o_req1_rdy}, {31'd0, first_id});
            g++;
         end
         tick();
         if (g == n_grants) begin
            i_req0_vld = 1'b0; i_req1_vld = 1'b0;
         end
      end
      check_val("grant_count", g, n_grants);
      i_req0_vld = 1'b0; i_req1_vld = 1'b0;
   endtask

   // Response monitor: pops the scoreboard on every accepted response.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         check_val("rdy_excl", {31'd0, o_req0_rdy & o_req1_rdy}, 32'd0);
         if (o_rsp_vld && i_rsp_rdy) begin
            check_val("rsp_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0)
               check_val("rsp", {16'd0, o_rsp_id, o_rsp_result, o_rsp_flag, o_rsp_err},
                         {16'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      // reset state
      neg();
      check_val("rst_rsp", {14'd0, o_busy, o_rsp_vld, o_rsp_id, o_rsp_err, o_rsp_flag, o_rsp_result}, 32'd0);
      check_val("rst_alu", {9'd0, o_alu_arg0, o_alu_arg1, o_alu_oper}, 32'd0);
      tick();
      i_rst_n = 1'b1;
      tick();

      // single request and latency
      set0(1'b1, 10'd64, 10'd16, 3'd0);
      push_exp(1'b0, 10'd64, 10'd16, 3'd0);
      neg(); check_val("single_rdy", {31'd0, o_req0_rdy}, 32'd1);
      tick(); i_req0_vld = 1'b0;
      neg();
      check_val("single_rdy_pulse", {31'd0, o_req0_rdy}, 32'd0);
      check_val("single_exec", {30'd0, o_busy, o_rsp_vld}, 32'd2);
      check_val("single_alu_arg0", {22'd0, o_alu_arg0}, 32'd64);
      tick(); neg(); check_val("single_lat", {31'd0, o_rsp_vld}, 32'd1);
      tick(); neg(); check_val("single_idle", {31'd0, o_busy}, 32'd0);

      // backpressure, with requester 0 waiting behind the stalled response
      tick();
      i_rsp_rdy = 1'b0;
      set1(1'b1, 10'h3F0, 10'h0FF, 3'd3);
      push_exp(1'b1, 10'h3F0, 10'h0FF, 3'd3);
      neg(); check_val("bp_rdy1", {31'd0, o_req1_rdy}, 32'd1);
      tick();
      i_req1_vld = 1'b0;
      set0(1'b1, 10'h005, 10'h0A0, 3'd4);
      push_exp(1'b0, 10'h005, 10'h0A0, 3'd4);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick(); neg();
         check_val("bp_hold", {18'd0, o_busy, o_rsp_vld, o_rsp_id, o_req0_rdy, o_rsp_result},
                   {18'd0, 1'b1, 1'b1, 1'b1, 1'b0, 10'h0F0});
      end
      tick(); i_rsp_rdy = 1'b1;
      tick(); neg();
      check_val("bp_release", {30'd0, o_busy, o_req0_rdy}, 32'd1);
      tick(); i_req0_vld = 1'b0;
      drain();

      // illegal opcode: straight to response, ALU operands untouched
      set1(1'b1, 10'd5, 10'd6, 3'd7);
      push_exp(1'b1, 10'd5, 10'd6, 3'd7);
      neg(); check_val("ill_rdy1", {31'd0, o_req1_rdy}, 32'd1);
      tick(); i_req1_vld = 1'b0;
      neg();
      check_val("ill_lat", {31'd0, o_rsp_vld}, 32'd1);
      check_val("ill_alu_hold", {9'd0, o_alu_arg0, o_alu_arg1, o_alu_oper},
                {9'd0, 10'h005, 10'h0A0, 3'd4});
      tick();
      drain();

      // contention: strict alternation starting at requester 0
      set0(1'b1, 10'd64, 10'd16, 3'd1);
      set1(1'b1, 10'd64, 10'd16, 3'd5);
      for (int i = 0; i < 3; i++) begin
         push_exp(1'b0, 10'd64, 10'd16, 3'd1);
         push_exp(1'b1, 10'd64, 10'd16, 3'd5);
      end
      run_pair(6, 1'b0);
      drain();

      // overflow pass-through and shifts
      set0(1'b1, 10'd511, 10'd511, 3'd0);
      push_exp(1'b0, 10'd511, 10'd511, 3'd0);
      tick(); tick(); i_req0_vld = 1'b0;
      drain();
      set0(1'b1, 10'h338, 10'h2D4, 3'd1);
      push_exp(1'b0, 10'h338, 10'h2D4, 3'd1);
      tick(); tick(); i_req0_vld = 1'b0;
      drain();
      set1(1'b1, 10'h300, 10'h3FD, 3'd2);
      push_exp(1'b1, 10'h300, 10'h3FD, 3'd2);
      tick(); tick(); i_req1_vld = 1'b0;
      drain();

      // asynchronous reset during EXEC drops the command
      set0(1'b1, 10'd100, 10'd23, 3'd0);
      neg(); check_val("mid_rdy0", {31'd0, o_req0_rdy}, 32'd1);
      tick(); i_req0_vld = 1'b0;
      neg(); check_val("mid_exec", {31'd0, o_busy}, 32'd1);
      #2; i_rst_n = 1'b0; #1;
      check_val("mid_rst_rsp", {14'd0, o_busy, o_rsp_vld, o_rsp_id, o_rsp_err, o_rsp_flag, o_rsp_result}, 32'd0);
      check_val("mid_rst_alu", {9'd0, o_alu_arg0, o_alu_arg1, o_alu_oper}, 32'd0);
      tick(); tick();
      i_rst_n = 1'b1;
      tick();
      set0(1'b1, 10'd64, 10'd16, 3'd1);
      set1(1'b1, 10'd64, 10'd16, 3'd5);
      push_exp(1'b0, 10'd64, 10'd16, 3'd1);
      push_exp(1'b1, 10'd64, 10'd16, 3'd5);
      run_pair(2, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one instance of the team's 10-bit signed combinational ALU between two independent requesters.
- Each requester uses a valid/ready handshake.
- The block arbitrates round-robin, drives the ALU from registered operands, and captures result and flags into a response register.
- The response returns the requester ID. It sits between the command sources and the ALU, which is instantiated next to it with its i_arg0/i_arg1/i_oper/o_result/o_flag ports tied to this block's o_alu_*/i_alu_* ports.

Parameters:
- W, 10, operand/result width (two's complement)
- OPW, 3, opcode width
- FLW, 4, flag width; treated as opaque, passed through unmodified
- MAX_OP, 6, highest legal opcode: 0 ADD, 1 SUB, 2 SHIFT, 3 AND, 4 ORR, 5 XOR, 6 XNOR

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req0_vld  in  1  requester 0 command valid
- i_req0_arg0  in  W  requester 0 operand A
- i_req0_arg1  in  W  requester 0 operand B (signed shift amount for SHIFT)
- i_req0_oper  in  OPW  requester 0 opcode
- o_req0_rdy  out  1  requester 0 command accepted this cycle
- i_req1_vld, i_req1_arg0, i_req1_arg1, i_req1_oper, o_req1_rdy  same widths and meanings, requester 1
- o_alu_arg0  out  W  ALU operand A
- o_alu_arg1  out  W  ALU operand B
- o_alu_oper  out  OPW  ALU opcode
- i_alu_result  in  W  ALU result (combinational from o_alu_*)
- i_alu_flag  in  FLW  ALU flags
- o_rsp_vld  out  1  response valid
- i_rsp_rdy  in  1  response consumer ready
- o_rsp_id  out  1  requester that issued the command
- o_rsp_result  out  W  captured result
- o_rsp_flag  out  FLW  captured flags
- o_rsp_err  out  1  opcode exceeded MAX_OP
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - State=IDLE; all o_alu_*, o_rsp_* and o_busy cleared to 0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Any in-flight command is dropped and no response is produced.
  - Deassertion takes effect at the next clock edge.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - grant0 = vld0 & (~vld1 | last==1); grant1 = vld1 & (~vld0 | last==0).
  - o_reqN_rdy = (state==IDLE) & grantN, combinational. At most one rdy is high per cycle.
  - On a rising edge with a grant:
    - Latch the granted arg0/arg1/oper into the operand registers that drive o_alu_*.
    - Set id to the granted index and last to the granted index.
    - If oper>MAX_OP, go to RESP directly with result=0, flag=0, err=1, and leave the operand registers unchanged.
    - Otherwise go to EXEC.
- EXEC (1 cycle): o_alu_* are stable from the registers. At the edge, capture i_alu_result→o_rsp_result and i_alu_flag→o_rsp_flag, set err=0, then go to RESP.
- RESP:
  - o_rsp_vld=1, and o_rsp_id/result/flag/err are held stable.
  - When i_rsp_vld & i_rsp_rdy at an edge (i.e. o_rsp_vld & i_rsp_rdy), go to IDLE.
  - No new command is accepted in RESP.
- Latency and throughput:
  - A command accepted at edge N produces o_rsp_vld high after edge N+1. With i_rsp_rdy=1 it is consumed at edge N+2.
  - Minimum issue spacing is 3 cycles.
- o_alu_* hold the last issued operands outside EXEC; they are not zeroed.
- Requesters must hold vld and payload stable until rdy. Dropping vld before rdy is legal and withdraws the request.
- Simultaneous vld0 & vld1 are alternated by last, so a continuously requesting pair is served strictly 0,1,0,1…
- Response backpressure is unbounded: the state stays in RESP and both rdy outputs stay 0.
- Arithmetic (wrap, overflow, shift direction) is entirely the ALU's concern. This block never modifies the result or flag bits.

Test Plan:
- Single request: r0 ADD arg0=64, arg1=16 with i_alu_* from the real ALU → o_req0_rdy for 1 cycle. Two edges later: o_rsp_vld=1, id=0, result=80, err=0.
- Contention: vld0 and vld1 held high continuously (r0 SUB 64−16, r1 XOR 64^16) → responses in order id0 result 48, id1 result 80, id0, id1…; never two consecutive grants to the same requester.
- Backpressure: i_rsp_rdy=0 for 5 cycles during RESP → o_rsp_* stable, o_req*_rdy=0, o_busy=1. Raising rdy → IDLE next cycle.
- Illegal opcode: r1 oper=7 → response one edge after accept with id=1, err=1, result=0, flag=0; o_alu_* unchanged.
- Pass-through at overflow: r0 ADD 511+511, then SUB −200−300 → o_rsp_result/flag bit-identical to the ALU outputs observed in EXEC.
- Reset mid-operation: assert i_rst_n=0 asynchronously during EXEC → all outputs 0 immediately with no clock edge. After release, simultaneous requests → r0 granted first.
